// File: rtl/iomem_bus_ctrl_if.sv
// iomem request/response bundle between the core (master) and the bus controller (slave).
interface iomem_bus_ctrl_if #(
    parameter int BLOCK_SIZE = 128
) ();
    localparam int NUMS_BYTE = BLOCK_SIZE / 8;

    logic                  iomem_valid;
    logic                  iomem_ready;
    logic                  iomem_err;
    logic [NUMS_BYTE-1:0]  iomem_wstrb;
    logic [31:0]           iomem_addr;
    logic [BLOCK_SIZE-1:0] iomem_wdata;
    logic [BLOCK_SIZE-1:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_err, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_err, iomem_rdata
    );
endinterface

// File: rtl/iomem_bus_ctrl.sv
// iomem-side controller: decodes RAM / timer / unmapped targets, applies programmable
// RAM latencies, and hosts the 64-bit mtime/mtimecmp timer with a level interrupt.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for iomem_valid; the cycle it is seen is the accept
// ST_WAIT   | counting down the remaining RAM latency; valid=0 aborts
// ST_RESP   | one-cycle ready (plus err for unmapped); valid ignored
module iomem_bus_ctrl #(
    parameter int          BLOCK_SIZE      = 128,
    parameter logic [31:0] RAM_BASE_ADDR   = 32'h4000_0000,
    parameter logic [31:0] RAM_MASK_ADDR   = 32'h000f_ffff,
    parameter int          RAM_RD_DELAY    = 16,
    parameter int          RAM_WR_DELAY    = 4,
    parameter logic [31:0] TIMER_BASE_ADDR = 32'h3000_0000,
    localparam int         NUMS_BYTE       = BLOCK_SIZE / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    iomem_bus_ctrl_if.slave       bus,
    output logic                  mem_rd_en_o,
    output logic [NUMS_BYTE-1:0]  mem_wstrb_o,
    input  logic [BLOCK_SIZE-1:0] mem_rdata_i,
    output logic [63:0]           timer_o,
    output logic                  timer_irq_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
    typedef enum logic [1:0] {TGT_RAM, TGT_TMR, TGT_UNM} tgt_e;

    // The accept cycle itself counts as the first latency cycle, so load D-1.
    localparam logic [7:0] RD_LOAD = 8'(RAM_RD_DELAY - 1);
    localparam logic [7:0] WR_LOAD = 8'(RAM_WR_DELAY - 1);

    state_e                state_q, state_d;
    tgt_e                  tgt_q, tgt_d;
    logic                  wr_q, wr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [BLOCK_SIZE-1:0] rdata_q, rdata_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  irq_q;

    logic                  tmr_hit;
    logic                  ram_hit;
    logic                  is_wr;
    logic                  accept;
    tgt_e                  req_tgt;
    logic [127:0]          tmr_pair;
    logic [127:0]          tmr_word;
    logic                  unused_ok;

    assign tmr_hit = (bus.iomem_addr[31:4] == TIMER_BASE_ADDR[31:4]);
    assign ram_hit = ((bus.iomem_addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR);
    assign is_wr   = |bus.iomem_wstrb;
    assign accept  = (state_q == ST_IDLE) && bus.iomem_valid;

    always_comb begin
        req_tgt = TGT_UNM;
        if (tmr_hit) begin
            req_tgt = TGT_TMR;
        end else if (ram_hit) begin
            req_tgt = TGT_RAM;
        end
    end

    assign tmr_pair = {mtimecmp_q, mtime_q};
    assign tmr_word = tmr_pair >> {bus.iomem_addr[3:2], 5'b0_0000};

    // Timer writes use absolute byte lanes; a written byte overrides the increment.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (accept && (req_tgt == TGT_TMR)) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.iomem_wstrb[i]) begin
                    mtime_d[8*i +: 8] = bus.iomem_wdata[8*i +: 8];
                end
                if (bus.iomem_wstrb[8+i]) begin
                    mtimecmp_d[8*i +: 8] = bus.iomem_wdata[64 + 8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_rd_en_o = 1'b0;
        mem_wstrb_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iomem_valid) begin
                    tgt_d   = req_tgt;
                    wr_d    = is_wr;
                    cnt_d   = 8'd0;
                    rdata_d = '0;
                    state_d = ST_RESP;
                    case (req_tgt)
                        TGT_RAM: begin
                            mem_rd_en_o = !is_wr;
                            mem_wstrb_o = bus.iomem_wstrb;
                            cnt_d       = is_wr ? WR_LOAD : RD_LOAD;
                            if (cnt_d != 8'd0) begin
                                state_d = ST_WAIT;
                            end
                        end
                        TGT_TMR: begin
                            if (!is_wr) begin
                                rdata_d = BLOCK_SIZE'(tmr_word);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT: begin
                if (!bus.iomem_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rdata_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tgt_q      <= TGT_UNM;
            wr_q       <= 1'b0;
            cnt_q      <= 8'd0;
            rdata_q    <= '0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign bus.iomem_ready = (state_q == ST_RESP);
    assign bus.iomem_err   = (state_q == ST_RESP) && (tgt_q == TGT_UNM);
    assign bus.iomem_rdata = ((state_q == ST_RESP) && (tgt_q == TGT_RAM) && !wr_q) ?
                             mem_rdata_i : rdata_q;

    assign timer_o     = mtime_q;
    assign timer_irq_o = irq_q;

    // Address byte offset and wide-block upper lanes have no function here.
    assign unused_ok = ^{bus.iomem_addr[1:0], bus.iomem_wdata, bus.iomem_wstrb};

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Directed bench for iomem_bus_ctrl: RAM latencies, timer access/irq/wrap, unmapped, abort, reset.
module tb_iomem_bus_ctrl;
    localparam int BS = 128;
    localparam logic [127:0] RAM_PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         sel = 1'b0;
    logic         valid = 1'b0;
    logic [31:0]  addr = '0;
    logic [15:0]  wstrb = '0;
    logic [127:0] wdata = '0;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    iomem_bus_ctrl_if #(.BLOCK_SIZE(BS)) bus1 ();
    iomem_bus_ctrl_if #(.BLOCK_SIZE(BS)) bus2 ();

    assign bus1.iomem_valid = valid & ~sel;
    assign bus1.iomem_addr  = addr;
    assign bus1.iomem_wstrb = wstrb;
    assign bus1.iomem_wdata = wdata;
    assign bus2.iomem_valid = valid & sel;
    assign bus2.iomem_addr  = addr;
    assign bus2.iomem_wstrb = wstrb;
    assign bus2.iomem_wdata = wdata;

    logic        rd_en1, rd_en2, irq1, irq2;
    logic [15:0] ws1, ws2;
    logic [63:0] tmr1, tmr2;

    iomem_bus_ctrl #(.BLOCK_SIZE(BS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus1),
        .mem_rd_en_o(rd_en1), .mem_wstrb_o(ws1), .mem_rdata_i(RAM_PAT),
        .timer_o(tmr1), .timer_irq_o(irq1)
    );

    iomem_bus_ctrl #(.BLOCK_SIZE(BS), .RAM_RD_DELAY(1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus2),
        .mem_rd_en_o(rd_en2), .mem_wstrb_o(ws2), .mem_rdata_i(RAM_PAT),
        .timer_o(tmr2), .timer_irq_o(irq2)
    );

    logic         ready, err, rd_en, irq;
    logic [15:0]  ws;
    logic [63:0]  tmr;
    logic [127:0] rdata;
    assign ready = sel ? bus2.iomem_ready : bus1.iomem_ready;
    assign err   = sel ? bus2.iomem_err   : bus1.iomem_err;
    assign rdata = sel ? bus2.iomem_rdata : bus1.iomem_rdata;
    assign rd_en = sel ? rd_en2 : rd_en1;
    assign ws    = sel ? ws2 : ws1;
    assign tmr   = sel ? tmr2 : tmr1;
    assign irq   = sel ? irq2 : irq1;

    // Drives one request at the next falling edge and holds it until ready (bounded).
    task automatic txn(input logic [31:0] a, input logic [15:0] s, input logic [127:0] d,
                       output int lat, output logic [127:0] rd, output logic er,
                       output logic acc_rd, output logic [15:0] acc_ws, output int extra,
                       output logic [63:0] acc_tmr);
        @(negedge clk);
        valid = 1'b1; addr = a; wstrb = s; wdata = d;
        #1;
        acc_rd = rd_en; acc_ws = ws; acc_tmr = tmr;
        lat = -1; rd = '1; er = 1'bx; extra = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (rd_en || (ws != 16'h0)) extra++;
            if (ready) begin
                lat = k; rd = rdata; er = err;
                break;
            end
        end
        valid = 1'b0; wstrb = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; #1 rst_n = 1'b0; #3;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (rd_en !== 1'b0 || ws !== 16'h0) begin bad++; $display("FAIL reset_mem got rd=%b ws=%h want 0", rd_en, ws); end
        total++; if (irq !== 1'b0 || tmr !== 64'h0) begin bad++; $display("FAIL reset_timer got irq=%b tmr=%h want 0", irq, tmr); end
        total++; if (rdata !== 128'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timer_read();
        int lat, ex; logic [127:0] rd; logic er, ar; logic [15:0] aw; logic [63:0] at;
        repeat (9) @(negedge clk);
        txn(32'h3000_0004, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (at !== 64'd10) begin bad++; $display("FAIL tmr_count10 got=%0d want=10", at); end
        total++; if (lat !== 1 || er !== 1'b0) begin bad++; $display("FAIL tmr_rd_lat got lat=%0d err=%b want 1/0", lat, er); end
        total++; if (rd !== 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0000) begin bad++; $display("FAIL tmr_rd_word1 got=%h want=0000_0000_ffff_ffff_ffff_ffff_0000_0000", rd); end
        total++; if (ar !== 1'b0 || aw !== 16'h0 || ex !== 0) begin bad++; $display("FAIL tmr_rd_nomem got rd=%b ws=%h extra=%0d want none", ar, aw, ex); end
        txn(32'h3000_0000, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (rd !== 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_000C) begin bad++; $display("FAIL tmr_rd_word0 got=%h want=ffff_ffff_ffff_ffff_0000_0000_0000_000c", rd); end
    endtask

    task automatic test_ram_read();
        int lat, ex; logic [127:0] rd; logic er, ar; logic [15:0] aw; logic [63:0] at;
        txn(32'h4000_0010, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (ar !== 1'b1 || ex !== 0) begin bad++; $display("FAIL ram_rd_pulse got acc=%b extra=%0d want 1/0", ar, ex); end
        total++; if (lat !== 16) begin bad++; $display("FAIL ram_rd_lat got=%0d want=16", lat); end
        total++; if (rd !== RAM_PAT || er !== 1'b0) begin bad++; $display("FAIL ram_rd_data got=%h err=%b want=%h err=0", rd, er, RAM_PAT); end
        txn(32'h400F_FFF0, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (lat !== 16 || er !== 1'b0 || ar !== 1'b1) begin bad++; $display("FAIL ram_rd_top got lat=%0d err=%b rd=%b want 16/0/1", lat, er, ar); end
    endtask

    task automatic test_ram_write();
        int lat, ex; logic [127:0] rd; logic er, ar; logic [15:0] aw; logic [63:0] at;
        txn(32'h4000_0020, 16'h00F0, {4{32'hA5A5_5A5A}}, lat, rd, er, ar, aw, ex, at);
        total++; if (aw !== 16'h00F0 || ar !== 1'b0 || ex !== 0) begin bad++; $display("FAIL ram_wr_strobe got ws=%h rd=%b extra=%0d want 00f0/0/0", aw, ar, ex); end
        total++; if (lat !== 4) begin bad++; $display("FAIL ram_wr_lat got=%0d want=4", lat); end
        total++; if (rd !== 128'h0 || er !== 1'b0) begin bad++; $display("FAIL ram_wr_resp got rdata=%h err=%b want 0/0", rd, er); end
    endtask

    task automatic test_short_read();
        int lat, ex; logic [127:0] rd; logic er, ar; logic [15:0] aw; logic [63:0] at;
        sel = 1'b1;
        txn(32'h4000_0010, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (lat !== 1 || ar !== 1'b1) begin bad++; $display("FAIL d1_rd_lat got lat=%0d rd=%b want 1/1", lat, ar); end
        total++; if (rd !== RAM_PAT) begin bad++; $display("FAIL d1_rd_data got=%h want=%h", rd, RAM_PAT); end
        sel = 1'b0;
    endtask

    task automatic test_unmapped();
        int lat, ex; logic [127:0] rd; logic er, ar; logic [15:0] aw; logic [63:0] at;
        txn(32'h1000_0000, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (lat !== 1 || er !== 1'b1) begin bad++; $display("FAIL unm_rd got lat=%0d err=%b want 1/1", lat, er); end
        total++; if (ar !== 1'b0 || aw !== 16'h0 || rd !== 128'h0) begin bad++; $display("FAIL unm_rd_side got rd=%b ws=%h rdata=%h want 0", ar, aw, rd); end
        txn(32'h1000_0000, 16'hFFFF, '1, lat, rd, er, ar, aw, ex, at);
        total++; if (lat !== 1 || er !== 1'b1 || aw !== 16'h0) begin bad++; $display("FAIL unm_wr got lat=%0d err=%b ws=%h want 1/1/0", lat, er, aw); end
        txn(32'h3000_0010, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL unm_past_timer got err=%b want 1", er); end
        txn(32'h4010_0000, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (er !== 1'b1 || ar !== 1'b0 || lat !== 1) begin bad++; $display("FAIL unm_past_ram got err=%b rd=%b lat=%0d want 1/0/1", er, ar, lat); end
    endtask

    task automatic test_irq_wrap();
        int lat, ex, rise; logic [127:0] rd; logic er, ar; logic [15:0] aw; logic [63:0] at;
        txn(32'h3000_0008, 16'hFFFF, {64'd100, 64'd0}, lat, rd, er, ar, aw, ex, at);
        total++; if (lat !== 1 || rd !== 128'h0 || er !== 1'b0) begin bad++; $display("FAIL tmr_wr_resp got lat=%0d rdata=%h err=%b want 1/0/0", lat, rd, er); end
        total++; if (tmr !== 64'd0) begin bad++; $display("FAIL tmr_wr_mtime got=%0d want=0", tmr); end
        rise = -1;
        for (int j = 2; j <= 120; j++) begin
            @(negedge clk);
            if (j == 101) begin
                total++; if (tmr !== 64'd100) begin bad++; $display("FAIL tmr_at100 got=%0d want=100", tmr); end
            end
            if (irq === 1'b1 && rise < 0) rise = j;
        end
        total++; if (rise !== 102) begin bad++; $display("FAIL irq_rise got cycle=%0d want=102", rise); end
        txn(32'h3000_000C, 16'h00FF, {64'd0, 64'hFFFF_FFFF_FFFF_FFFE}, lat, rd, er, ar, aw, ex, at);
        total++; if (tmr !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL wrap_load got=%h want=fffffffffffffffe", tmr); end
        @(negedge clk);
        total++; if (tmr !== 64'hFFFF_FFFF_FFFF_FFFF || irq !== 1'b1) begin bad++; $display("FAIL wrap_max got tmr=%h irq=%b want ffffffffffffffff/1", tmr, irq); end
        @(negedge clk);
        total++; if (tmr !== 64'd0) begin bad++; $display("FAIL wrap_zero got=%h want=0", tmr); end
        @(negedge clk);
        total++; if (irq !== 1'b0 || tmr !== 64'd1) begin bad++; $display("FAIL wrap_irq_low got irq=%b tmr=%h want 0/1", irq, tmr); end
        txn(32'h3000_0000, 16'h0002, {120'd0, 8'hAB, 8'h00}, lat, rd, er, ar, aw, ex, at);
        total++; if (tmr !== 64'h0000_0000_0000_AB03) begin bad++; $display("FAIL tmr_byte_wr got=%h want=ab03", tmr); end
    endtask

    task automatic test_abort();
        int lat, ex, seen; logic [127:0] rd; logic er, ar; logic [15:0] aw; logic [63:0] at;
        seen = 0;
        @(negedge clk);
        valid = 1'b1; addr = 32'h4000_0010; wstrb = 16'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ready || err) seen++;
        end
        valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ready || err) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_noresp got=%0d responses want=0", seen); end
        txn(32'h4000_0010, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (lat !== 16 || rd !== RAM_PAT || ar !== 1'b1) begin bad++; $display("FAIL abort_next got lat=%0d rd=%b want 16/1", lat, ar); end
    endtask

    task automatic test_back_to_back();
        int errs, cnt;
        errs = 0; cnt = 0;
        @(negedge clk);
        valid = 1'b1; addr = 32'h1000_0000; wstrb = 16'h0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready !== (k % 2 == 1) || err !== (k % 2 == 1)) errs++;
            if (ready) cnt++;
        end
        valid = 1'b0;
        total++; if (errs !== 0 || cnt !== 5) begin bad++; $display("FAIL b2b_pattern got bad_cycles=%0d readies=%0d want 0/5", errs, cnt); end
    endtask

    task automatic test_reset_mid();
        int lat, ex, seen; logic [127:0] rd; logic er, ar; logic [15:0] aw; logic [63:0] at;
        seen = 0;
        @(negedge clk);
        valid = 1'b1; addr = 32'h4000_0010; wstrb = 16'h0;
        repeat (3) @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b want=1", irq); end
        valid = 1'b0; rst_n = 1'b0; #1;
        total++; if (ready !== 1'b0 || err !== 1'b0 || rd_en !== 1'b0 || ws !== 16'h0) begin bad++; $display("FAIL midrst_bus got rdy=%b err=%b rd=%b ws=%h want 0", ready, err, rd_en, ws); end
        total++; if (irq !== 1'b0 || tmr !== 64'h0 || rdata !== 128'h0) begin bad++; $display("FAIL midrst_timer got irq=%b tmr=%h rdata=%h want 0", irq, tmr, rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_noresp got=%0d want=0", seen); end
        txn(32'h3000_0008, 16'h0, '0, lat, rd, er, ar, aw, ex, at);
        total++; if (rd !== 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL midrst_cmp got=%h want=0000_0000_0000_0000_ffff_ffff_ffff_ffff", rd); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_timer_read();
        test_ram_read();
        test_ram_write();
        test_short_read();
        test_unmapped();
        test_irq_wrap();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
